// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential mul/div/add/sub unit.
package seq_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/iter_muldiv_core.sv
// One-bit-per-step datapath: shift-add multiply and restoring divide.
module iter_muldiv_core #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] res_o,
  output logic               zero_div_o
);

  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q, quo_q, dvsr_q;
  logic [WIDTH:0]     rem_q, shifted, trial;
  logic               is_div_q, zero_q, borrow;

  // Bring down the next dividend bit and try subtracting the divisor.
  // A zero divisor never borrows, so quotient saturates to all ones and
  // the remainder ends up equal to the dividend.
  always_comb begin
    shifted         = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    {borrow, trial} = {1'b0, shifted} - {2'b00, dvsr_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      is_div_q <= 1'b0;
      zero_q   <= 1'b0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      rem_q    <= '0;
      quo_q    <= a_i;
      dvsr_q   <= b_i;
      is_div_q <= is_div_i;
      zero_q   <= is_div_i && (b_i == '0);
    end else if (step_i) begin
      if (is_div_q) begin
        rem_q <= borrow ? shifted : trial;
        quo_q <= {quo_q[WIDTH-2:0], ~borrow};
      end else begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end

  assign res_o      = is_div_q ? {rem_q[WIDTH-1:0], quo_q} : acc_q;
  assign zero_div_o = zero_q;

endmodule

// File: rtl/seq_muldiv_alu.sv
// Single-transaction arithmetic unit: add/sub in one edge, mul/div iterate WIDTH edges.
module seq_muldiv_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [1:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               div_by_zero,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q;
  logic [2*WIDTH-1:0] as_q, as_d, core_res;
  logic [WIDTH:0]     sum, diff;
  logic               accept, core_zero;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);

  // diff[WIDTH] is the borrow of the unsigned subtraction.
  always_comb begin
    sum  = {1'b0, in1} + {1'b0, in2};
    diff = {1'b0, in1} - {1'b0, in2};
    as_d = {{(WIDTH-1){1'b0}}, (opcode[0] ? diff : sum)};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        cnt_d   = '0;
        state_d = opcode[1] ? BUSY : DONE;
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      as_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q <= op_e'(opcode);
        as_q <= as_d;
      end
    end
  end

  iter_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept && opcode[1]),
    .step_i     (busy),
    .is_div_i   (opcode[0]),
    .a_i        (in1),
    .b_i        (in2),
    .res_o      (core_res),
    .zero_div_o (core_zero)
  );

  // Outputs are gated by DONE so a reset or idle unit always shows zero.
  assign out         = out_valid ? (op_q[1] ? core_res : as_q) : '0;
  assign div_by_zero = out_valid && (op_q == OP_DIV) && core_zero;

endmodule

// File: tb/tb_seq_muldiv_alu.sv
// Directed vector bench for seq_muldiv_alu at WIDTH=4.
module tb_seq_muldiv_alu;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready, div_by_zero, busy;
  logic [W-1:0]   in1, in2;
  logic [1:0]     opcode;
  logic [2*W-1:0] out;

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_out;
    logic           exp_dbz;
    int             exp_lat;
  } vec_t;

  seq_muldiv_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .opcode      (opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; leaves the bench #1 after the handshake edge.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    string tag;
    tag = $sformatf("vec%0d", idx);
    in_valid = 1'b1; opcode = v.op; in1 = v.a; in2 = v.b;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = ~v.op; in1 = ~v.a; in2 = ~v.b;
    if (v.op[1]) chk({tag, " busy"}, {30'd0, busy, in_ready}, 32'b10);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " out"}, 32'(out), 32'(v.exp_out));
    chk({tag, " dbz"}, 32'(div_by_zero), 32'(v.exp_dbz));
    @(posedge clk); #1;
    chk({tag, " ready_after"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  vec_t vecs[$];

  initial begin
    int seen;
    // op, a, b, expected out, expected dbz, extra edges after accept
    vecs.push_back('{2'b10, 4'd2,  4'd3,  8'h06, 1'b0, 4});
    vecs.push_back('{2'b11, 4'd6,  4'd3,  8'h02, 1'b0, 4});
    vecs.push_back('{2'b11, 4'd13, 4'd4,  8'h13, 1'b0, 4});
    vecs.push_back('{2'b11, 4'd7,  4'd0,  8'h7F, 1'b1, 4});
    vecs.push_back('{2'b00, 4'd15, 4'd15, 8'h1E, 1'b0, 0});
    vecs.push_back('{2'b01, 4'd3,  4'd5,  8'h1E, 1'b0, 0});
    vecs.push_back('{2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 4});
    vecs.push_back('{2'b01, 4'd9,  4'd2,  8'h07, 1'b0, 0});
    vecs.push_back('{2'b00, 4'd0,  4'd0,  8'h00, 1'b0, 0});
    vecs.push_back('{2'b11, 4'd15, 4'd1,  8'h0F, 1'b0, 4});
    vecs.push_back('{2'b11, 4'd15, 4'd15, 8'h01, 1'b0, 4});
    vecs.push_back('{2'b11, 4'd3,  4'd7,  8'h30, 1'b0, 4});
    vecs.push_back('{2'b11, 4'd0,  4'd0,  8'h0F, 1'b1, 4});
    vecs.push_back('{2'b10, 4'd0,  4'd9,  8'h00, 1'b0, 4});
    vecs.push_back('{2'b10, 4'd11, 4'd13, 8'h8F, 1'b0, 4});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; opcode = 2'b00;
    #12;
    chk("reset outputs", {27'd0, in_ready, out_valid, div_by_zero, busy, |out}, 32'b10000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Backpressure: result must hold and no new operation may be taken.
    out_ready = 1'b0;
    run_vec_hold: begin
      in_valid = 1'b1; opcode = 2'b10; in1 = 4'd5; in2 = 4'd5;
      @(posedge clk); #1;
      in1 = 4'd1; in2 = 4'd2; opcode = 2'b00;
      seen = 0;
      while (!out_valid && seen < 40) begin
        @(posedge clk); #1;
        seen++;
      end
      chk("bp latency", 32'(seen), 32'd4);
      for (int c = 0; c < 6; c++) begin
        chk($sformatf("bp hold%0d", c), {21'd0, out_valid, in_ready, div_by_zero, out}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h19});
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp handshake", {30'd0, out_valid, in_ready}, 32'b01);
      @(posedge clk); #1;
      chk("bp no accept", {29'd0, busy, out_valid, in_ready}, 32'b001);
    end

    // Reset in the middle of a multiply drops it.
    in_valid = 1'b1; opcode = 2'b10; in1 = 4'd9; in2 = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst mid busy", {28'd0, in_ready, out_valid, busy, |out}, 32'b1000);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen++;
    end
    chk("no stale result", 32'(seen), 32'd0);
    run_vec(99, '{2'b00, 4'd1, 4'd1, 8'h02, 1'b0, 0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
